pa_fpu_wb_retire: RTL and testbench

- Downstream consumer of the FPU forward bus (data/fflags/valid to IDU).
- Tracks destination registers of in-flight FP ops, pairs each returning result with its rd, writes the FP register file one cycle later, and accumulates exception flags into fcsr.fflags.
- Exports a per-register busy scoreboard and issue-ready signals so the IDU stalls on RAW hazards and resource limits.

---
 rtl/pa_fpu_wb_retire.sv | 164 ++++++++++++++++
 tb/tb_pa_fpu_wb_retire.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_fpu_wb_retire.sv
// FPU writeback retire stage: pairs forward-bus results with their destination
// registers, writes the FP register file one cycle later, accumulates sticky
// exception flags and exports a per-register busy scoreboard to the IDU.
module pa_fpu_wb_retire #(
  parameter int EX_DEPTH = 2
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        idu_fpu_issue_vld,
  input  logic        idu_fpu_issue_long,
  input  logic [4:0]  idu_fpu_issue_rd,
  output logic        fpu_idu_issue_short_rdy,
  output logic        fpu_idu_issue_long_rdy,
  input  logic        fpu_idu_fwd_vld,
  input  logic        fpu_idu_fwd_src_fdsu,
  input  logic [31:0] fpu_idu_fwd_data,
  input  logic [4:0]  fpu_idu_fwd_fflags,
  input  logic        idu_fpu_flush,
  input  logic        csr_fflags_wen,
  input  logic [4:0]  csr_fflags_wdata,
  output logic        fpr_wen,
  output logic [4:0]  fpr_waddr,
  output logic [31:0] fpr_wdata,
  output logic [4:0]  fcsr_fflags,
  output logic [31:0] fpr_busy,
  output logic        wb_proto_err
);

  localparam int PTR_W = $clog2(EX_DEPTH);
  localparam int CNT_W = $clog2(EX_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(EX_DEPTH);

  logic [4:0]       tagFifo_q [EX_DEPTH];
  logic [4:0]       tagFifo_d [EX_DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             slotVld_q, slotVld_d;
  logic [4:0]       slotRd_q, slotRd_d;
  logic [1:0]       pend_q [32];
  logic [1:0]       pend_d [32];
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             protoErr_q, protoErr_d;

  logic shortIss, longIss, popReq, fdsuReq;
  logic popOk, fdsuOk, pushOk, longOk, capture, issueHit, errNow, fifoFull;
  logic [4:0] capTag;

  // Classify this cycle's issue/result traffic and decide what is accepted.
  always_comb begin
    shortIss = idu_fpu_issue_vld & ~idu_fpu_issue_long;
    longIss  = idu_fpu_issue_vld & idu_fpu_issue_long;
    popReq   = fpu_idu_fwd_vld & ~fpu_idu_fwd_src_fdsu;
    fdsuReq  = fpu_idu_fwd_vld & fpu_idu_fwd_src_fdsu;
    fifoFull = (count_q == DEPTH_C);
    popOk    = popReq & (count_q != '0);
    fdsuOk   = fdsuReq & slotVld_q;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    pushOk   = shortIss & (~fifoFull | popOk);
    longOk   = longIss & ~slotVld_q;
    issueHit = ~idu_fpu_flush & (pushOk | longOk);
    capture  = ~idu_fpu_flush & (popOk | fdsuOk);
    capTag   = fpu_idu_fwd_src_fdsu ? slotRd_q : tagFifo_q[rdPtr_q];
    errNow   = ~idu_fpu_flush & ((shortIss & ~pushOk) | (longIss & ~longOk) |
                                 (popReq & ~popOk) | (fdsuReq & ~fdsuOk));
  end

  // Next-state for tag tracking, scoreboard, writeback and flags.
  always_comb begin
    tagFifo_d  = tagFifo_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    slotVld_d  = slotVld_q;
    slotRd_d   = slotRd_q;
    pend_d     = pend_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    fflags_d   = fflags_q;
    protoErr_d = protoErr_q | errNow;
    if (idu_fpu_flush) begin
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
      slotVld_d = 1'b0;
      for (int i = 0; i < 32; i++) pend_d[i] = 2'd0;
    end else begin
      if (pushOk) begin
        tagFifo_d[wrPtr_q] = idu_fpu_issue_rd;
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popOk) rdPtr_d = rdPtr_q + PTR_W'(1);
      count_d = count_q + {{(CNT_W-1){1'b0}}, pushOk} - {{(CNT_W-1){1'b0}}, popOk};
      if (fdsuOk) slotVld_d = 1'b0;
      if (longOk) begin
        slotVld_d = 1'b1;
        slotRd_d  = idu_fpu_issue_rd;
      end
      if (capture) begin
        wen_d   = 1'b1;
        waddr_d = capTag;
        wdata_d = fpu_idu_fwd_data;
      end
      for (int i = 0; i < 32; i++) begin
        pend_d[i] = pend_q[i]
                  + {1'b0, issueHit && (idu_fpu_issue_rd == 5'(i))}
                  - {1'b0, capture && (capTag == 5'(i))};
      end
    end
    if (capture && csr_fflags_wen)  fflags_d = csr_fflags_wdata | fpu_idu_fwd_fflags;
    else if (capture)               fflags_d = fflags_q | fpu_idu_fwd_fflags;
    else if (csr_fflags_wen)        fflags_d = csr_fflags_wdata;
  end

  // Tag FIFO storage; contents are only meaningful below the count.
  always_ff @(posedge forever_cpuclk) begin
    tagFifo_q <= tagFifo_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      slotVld_q  <= 1'b0;
      slotRd_q   <= '0;
      for (int i = 0; i < 32; i++) pend_q[i] <= 2'd0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      fflags_q   <= '0;
      protoErr_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      slotVld_q  <= slotVld_d;
      slotRd_q   <= slotRd_d;
      pend_q     <= pend_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      fflags_q   <= fflags_d;
      protoErr_q <= protoErr_d;
    end
  end

  // Export registered state; busy means at least one pending write to that rd.
  always_comb begin
    fpu_idu_issue_short_rdy = (count_q < DEPTH_C);
    fpu_idu_issue_long_rdy  = ~slotVld_q;
    fpr_wen      = wen_q;
    fpr_waddr    = waddr_q;
    fpr_wdata    = wdata_q;
    fcsr_fflags  = fflags_q;
    wb_proto_err = protoErr_q;
    for (int i = 0; i < 32; i++) fpr_busy[i] = (pend_q[i] != 2'd0);
  end

endmodule

// File: tb/tb_pa_fpu_wb_retire.sv
// Directed bench for pa_fpu_wb_retire: a queue-based reference model is
// compared against every output after every clock edge, and hand-computed
// literal expectations pin the key scenarios.
module tb_pa_fpu_wb_retire;

  localparam int EX_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        issVld, issLong;
  logic [4:0]  issRd;
  logic        shortRdy, longRdy;
  logic        fwdVld, fwdFdsu;
  logic [31:0] fwdData;
  logic [4:0]  fwdFlags;
  logic        flush;
  logic        csrWen;
  logic [4:0]  csrWdata;
  logic        fprWen;
  logic [4:0]  fprWaddr;
  logic [31:0] fprWdata;
  logic [4:0]  fflagsOut;
  logic [31:0] busyOut;
  logic        protoErr;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          shortQ[$];
  bit          slotVldM;
  int          slotRdM;
  int          busyCntM[32];
  bit          wenM;
  logic [4:0]  waddrM;
  logic [31:0] wdataM;
  logic [4:0]  fflagsM;
  bit          errM;

  pa_fpu_wb_retire #(.EX_DEPTH(EX_DEPTH)) dut (
    .forever_cpuclk          (clk),
    .cpurst                  (rst),
    .idu_fpu_issue_vld       (issVld),
    .idu_fpu_issue_long      (issLong),
    .idu_fpu_issue_rd        (issRd),
    .fpu_idu_issue_short_rdy (shortRdy),
    .fpu_idu_issue_long_rdy  (longRdy),
    .fpu_idu_fwd_vld         (fwdVld),
    .fpu_idu_fwd_src_fdsu    (fwdFdsu),
    .fpu_idu_fwd_data        (fwdData),
    .fpu_idu_fwd_fflags      (fwdFlags),
    .idu_fpu_flush           (flush),
    .csr_fflags_wen          (csrWen),
    .csr_fflags_wdata        (csrWdata),
    .fpr_wen                 (fprWen),
    .fpr_waddr               (fprWaddr),
    .fpr_wdata               (fprWdata),
    .fcsr_fflags             (fflagsOut),
    .fpr_busy                (busyOut),
    .wb_proto_err            (protoErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; issVld = 1'b0; issLong = 1'b0; issRd = '0;
    fwdVld = 1'b0; fwdFdsu = 1'b0; fwdData = '0; fwdFlags = '0;
    flush = 1'b0; csrWen = 1'b0; csrWdata = '0;
  endtask

  task automatic issue(input bit isLong, input int rd);
    issVld = 1'b1; issLong = isLong; issRd = 5'(rd);
  endtask

  task automatic result(input bit fromFdsu, input logic [31:0] data, input logic [4:0] fl);
    fwdVld = 1'b1; fwdFdsu = fromFdsu; fwdData = data; fwdFlags = fl;
  endtask

  // Advance the model by one edge using the driven inputs, in terms of
  // queue/slot ownership rather than any hardware encoding.
  task automatic modelStep();
    bit popping, fdsuHit, captured;
    int tag;
    captured = 0;
    tag = 0;
    if (rst) begin
      shortQ.delete(); slotVldM = 0; slotRdM = 0;
      foreach (busyCntM[i]) busyCntM[i] = 0;
      wenM = 0; waddrM = '0; wdataM = '0; fflagsM = '0; errM = 0;
      return;
    end
    wenM = 0;
    if (flush) begin
      shortQ.delete(); slotVldM = 0;
      foreach (busyCntM[i]) busyCntM[i] = 0;
    end else begin
      popping = fwdVld && !fwdFdsu && shortQ.size() > 0;
      fdsuHit = fwdVld && fwdFdsu && slotVldM;
      if (fwdVld && !(popping || fdsuHit)) errM = 1;
      if (popping) begin tag = shortQ.pop_front(); captured = 1; end
      if (fdsuHit) begin tag = slotRdM; slotVldM = 0; captured = 1; end
      if (captured) begin
        wenM = 1; waddrM = 5'(tag); wdataM = fwdData;
        busyCntM[tag]--;
      end
      if (issVld && !issLong) begin
        if (shortQ.size() < EX_DEPTH || popping) begin
          shortQ.push_back(int'(issRd)); busyCntM[issRd]++;
        end else errM = 1;
      end
      if (issVld && issLong) begin
        if (!(slotVldM || fdsuHit)) begin
          slotVldM = 1; slotRdM = int'(issRd); busyCntM[issRd]++;
        end else errM = 1;
      end
    end
    if (captured && csrWen) fflagsM = csrWdata | fwdFlags;
    else if (captured)      fflagsM = fflagsM | fwdFlags;
    else if (csrWen)        fflagsM = csrWdata;
  endtask

  task automatic checkOutput();
    logic [31:0] expBusy;
    for (int i = 0; i < 32; i++) expBusy[i] = (busyCntM[i] != 0);
    checkValue("fpr_wen", 32'(fprWen), 32'(wenM));
    checkValue("fpr_waddr", 32'(fprWaddr), 32'(waddrM));
    checkValue("fpr_wdata", fprWdata, wdataM);
    checkValue("fcsr_fflags", 32'(fflagsOut), 32'(fflagsM));
    checkValue("fpr_busy", busyOut, expBusy);
    checkValue("wb_proto_err", 32'(protoErr), 32'(errM));
    checkValue("short_rdy", 32'(shortRdy), 32'(shortQ.size() < EX_DEPTH));
    checkValue("long_rdy", 32'(longRdy), 32'(!slotVldM));
  endtask

  // One clock: inputs already driven, model and DUT advance, outputs compared
  // one time unit after the edge, then inputs return to idle.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1; applyStimulus();
    rst = 1'b1; applyStimulus();
    checkValue("reset busy", busyOut, 32'h0);
    checkValue("reset short_rdy", 32'(shortRdy), 32'd1);
    checkValue("reset long_rdy", 32'(longRdy), 32'd1);
    checkValue("reset err", 32'(protoErr), 32'd0);
    checkValue("reset wdata", fprWdata, 32'h0);

    // Single short op with writeback one cycle after the result
    issue(0, 3); applyStimulus();
    checkValue("t1 busy3 set", 32'(busyOut[3]), 32'd1);
    applyStimulus();
    result(0, 32'h3F80_0000, 5'b00001); applyStimulus();
    checkValue("t1 wen", 32'(fprWen), 32'd1);
    checkValue("t1 waddr", 32'(fprWaddr), 32'd3);
    checkValue("t1 wdata", fprWdata, 32'h3F80_0000);
    checkValue("t1 fflags", 32'(fflagsOut), 32'b00001);
    checkValue("t1 busy3 clr", 32'(busyOut[3]), 32'd0);
    applyStimulus();
    checkValue("t1 wen drop", 32'(fprWen), 32'd0);

    // Long op overtaken by a short op; second long while slot busy
    issue(1, 7); applyStimulus();
    checkValue("t2 long_rdy low", 32'(longRdy), 32'd0);
    issue(0, 9); applyStimulus();
    result(0, 32'hAAAA_0009, 5'b0); applyStimulus();
    checkValue("t2 first waddr", 32'(fprWaddr), 32'd9);
    issue(1, 10); applyStimulus();
    checkValue("t2 err", 32'(protoErr), 32'd1);
    result(1, 32'hBBBB_0007, 5'b0); applyStimulus();
    checkValue("t2 second waddr", 32'(fprWaddr), 32'd7);
    checkValue("t2 long_rdy back", 32'(longRdy), 32'd1);

    // Full FIFO with simultaneous push and pop
    issue(0, 1); applyStimulus();
    issue(0, 2); applyStimulus();
    checkValue("t3 full short_rdy", 32'(shortRdy), 32'd0);
    issue(0, 4); result(0, 32'hC1, 5'b0); applyStimulus();
    checkValue("t3 waddr 1", 32'(fprWaddr), 32'd1);
    checkValue("t3 still full", 32'(shortRdy), 32'd0);
    result(0, 32'hC2, 5'b0); applyStimulus();
    checkValue("t3 waddr 2", 32'(fprWaddr), 32'd2);
    result(0, 32'hC4, 5'b0); applyStimulus();
    checkValue("t3 waddr 4", 32'(fprWaddr), 32'd4);
    checkValue("t3 wdata 4", fprWdata, 32'hC4);
    checkValue("t3 drained", 32'(shortRdy), 32'd1);

    // Two pending writes to the same register
    issue(0, 5); applyStimulus();
    issue(0, 5); applyStimulus();
    result(0, 32'h51, 5'b0); applyStimulus();
    checkValue("t4 busy5 held", 32'(busyOut[5]), 32'd1);
    result(0, 32'h52, 5'b0); applyStimulus();
    checkValue("t4 busy5 clr", 32'(busyOut[5]), 32'd0);

    // CSR write racing a result's flags
    csrWen = 1'b1; csrWdata = 5'b10000; applyStimulus();
    checkValue("t5 csr load", 32'(fflagsOut), 32'b10000);
    issue(0, 11); applyStimulus();
    result(0, 32'h11, 5'b00100); csrWen = 1'b1; csrWdata = 5'b00000; applyStimulus();
    checkValue("t5 merged", 32'(fflagsOut), 32'b00100);

    // Flush discards in-flight ops; the later result is unmatched
    rst = 1'b1; applyStimulus();
    issue(0, 6); applyStimulus();
    issue(0, 8); applyStimulus();
    flush = 1'b1; applyStimulus();
    checkValue("t6 busy cleared", busyOut, 32'h0);
    result(0, 32'h66, 5'b11111); applyStimulus();
    checkValue("t6 no wen", 32'(fprWen), 32'd0);
    checkValue("t6 err", 32'(protoErr), 32'd1);
    checkValue("t6 fflags kept", 32'(fflagsOut), 32'd0);

    // Flush in the same cycle as an issue and a matching result
    issue(0, 12); applyStimulus();
    issue(0, 13); result(0, 32'h12, 5'b00010); flush = 1'b1; applyStimulus();
    checkValue("t7 no wen", 32'(fprWen), 32'd0);
    checkValue("t7 busy", busyOut, 32'h0);
    checkValue("t7 fflags", 32'(fflagsOut), 32'd0);

    // Reset mid-operation drops the in-flight op
    issue(1, 14); applyStimulus();
    rst = 1'b1; applyStimulus();
    result(1, 32'h14, 5'b0); applyStimulus();
    checkValue("t8 no wen", 32'(fprWen), 32'd0);
    checkValue("t8 err after reset", 32'(protoErr), 32'd1);
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
